// File: rtl/perceptron_bp_pipelined.sv
// Perceptron branch predictor: decode-time prediction with a speculative GHR,
// checkpoint restore on mispredict, and a read/compute/write weight trainer.
// Ports: clk, rst_n (async, active low);
//   req_valid/req_pc -> pred_valid/pred_taken/pred_ghr (1-cycle, registered);
//   fb_valid/fb_ready handshake with fb_pc/fb_ghr/fb_taken/fb_mispredict.
module perceptron_bp_pipelined #(
    parameter int ENTRIES  = 64,
    parameter int HIST_LEN = 16,
    parameter int WEIGHT_W = 8,
    parameter int PC_LSB   = 2,
    parameter int THETA    = 44
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    input  logic [31:0]         req_pc,
    output logic                pred_valid,
    output logic                pred_taken,
    output logic [HIST_LEN-1:0] pred_ghr,
    input  logic                fb_valid,
    output logic                fb_ready,
    input  logic [31:0]         fb_pc,
    input  logic [HIST_LEN-1:0] fb_ghr,
    input  logic                fb_taken,
    input  logic                fb_mispredict
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int SUM_W = WEIGHT_W + $clog2(HIST_LEN + 1) + 1;

    localparam logic [WEIGHT_W-1:0] W_MAX = {1'b0, {(WEIGHT_W-1){1'b1}}};
    localparam logic [WEIGHT_W-1:0] W_MIN = {1'b1, {(WEIGHT_W-1){1'b0}}};
    localparam logic [SUM_W-1:0]    THETA_V = SUM_W'(THETA);

    typedef logic [HIST_LEN:0][WEIGHT_W-1:0] row_t;
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    // Two's-complement sum kept in plain bits; sign is the MSB.
    function automatic logic [SUM_W-1:0] dot(
        input row_t                row,
        input logic [HIST_LEN-1:0] ghr
    );
        logic [SUM_W-1:0] acc;
        logic [SUM_W-1:0] wx;
        acc = {{(SUM_W-WEIGHT_W){row[0][WEIGHT_W-1]}}, row[0]};
        for (int i = 1; i <= HIST_LEN; i++) begin
            wx = {{(SUM_W-WEIGHT_W){row[i][WEIGHT_W-1]}}, row[i]};
            if (ghr[i-1]) acc = acc + wx;
            else          acc = acc - wx;
        end
        return acc;
    endfunction

    function automatic logic [WEIGHT_W-1:0] sat_step(
        input logic [WEIGHT_W-1:0] w,
        input logic                up
    );
        if (up) return (w == W_MAX) ? w : w + 1'b1;
        else    return (w == W_MIN) ? w : w - 1'b1;
    endfunction

    // t*x_i is +1 exactly when the outcome matches the history bit.
    function automatic row_t train_row(
        input row_t                row,
        input logic [HIST_LEN-1:0] ghr,
        input logic                tk
    );
        row_t r;
        r[0] = sat_step(row[0], tk);
        for (int i = 1; i <= HIST_LEN; i++) begin
            r[i] = sat_step(row[i], tk == ghr[i-1]);
        end
        return r;
    endfunction

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [HIST_LEN-1:0] ghr_q, ghr_d;
    logic                taken_q, taken_d;
    row_t                row_q, row_d;
    logic                train_q, train_d;
    logic [HIST_LEN-1:0] spec_ghr_q, spec_ghr_d;
    logic                pred_valid_q, pred_valid_d;
    logic                pred_taken_q, pred_taken_d;
    logic [HIST_LEN-1:0] pred_ghr_q, pred_ghr_d;
    row_t                w_q [ENTRIES];
    row_t                w_d [ENTRIES];

    logic [IDX_W-1:0] req_idx;
    logic [SUM_W-1:0] y_pred;
    logic             pred_dir;
    logic [SUM_W-1:0] y_fb;
    logic [SUM_W-1:0] y_abs;
    logic             fb_dir;
    logic             need_train;
    logic             fb_fire;
    logic             unused_pc;

    assign unused_pc = ^{req_pc, fb_pc};

    assign fb_ready   = (state_q == IDLE);
    assign fb_fire    = fb_valid & fb_ready;
    assign pred_valid = pred_valid_q;
    assign pred_taken = pred_taken_q;
    assign pred_ghr   = pred_ghr_q;

    always_comb begin
        req_idx    = req_pc[PC_LSB +: IDX_W];
        y_pred     = dot(w_q[req_idx], spec_ghr_q);
        pred_dir   = ~y_pred[SUM_W-1];
        y_fb       = dot(w_q[idx_q], ghr_q);
        fb_dir     = ~y_fb[SUM_W-1];
        y_abs      = fb_dir ? y_fb : -y_fb;
        need_train = (fb_dir != taken_q) || (y_abs <= THETA_V);
    end

    always_comb begin
        pred_valid_d = req_valid;
        pred_taken_d = req_valid ? pred_dir : pred_taken_q;
        pred_ghr_d   = req_valid ? spec_ghr_q : pred_ghr_q;
        spec_ghr_d   = spec_ghr_q;
        if (req_valid) begin
            spec_ghr_d = {spec_ghr_q[HIST_LEN-2:0], pred_dir};
        end
        // Restore wins over a same-cycle speculative shift.
        if (fb_fire && fb_mispredict) begin
            spec_ghr_d = {fb_ghr[HIST_LEN-2:0], fb_taken};
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ghr_d   = ghr_q;
        taken_d = taken_q;
        row_d   = row_q;
        train_d = train_q;
        unique case (state_q)
            IDLE: begin
                if (fb_valid) begin
                    idx_d   = fb_pc[PC_LSB +: IDX_W];
                    ghr_d   = fb_ghr;
                    taken_d = fb_taken;
                    state_d = READ;
                end
            end
            READ: begin
                row_d   = train_row(w_q[idx_q], ghr_q, taken_q);
                train_d = need_train;
                state_d = WRITE;
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Writes land at the edge ending WRITE, so a same-cycle read sees old weights.
    always_comb begin
        for (int e = 0; e < ENTRIES; e++) begin
            w_d[e] = w_q[e];
        end
        if (state_q == WRITE && train_q) begin
            w_d[idx_q] = row_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            ghr_q        <= '0;
            taken_q      <= 1'b0;
            row_q        <= '0;
            train_q      <= 1'b0;
            spec_ghr_q   <= '0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_ghr_q   <= '0;
            for (int e = 0; e < ENTRIES; e++) begin
                w_q[e] <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            ghr_q        <= ghr_d;
            taken_q      <= taken_d;
            row_q        <= row_d;
            train_q      <= train_d;
            spec_ghr_q   <= spec_ghr_d;
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_ghr_q   <= pred_ghr_d;
            for (int e = 0; e < ENTRIES; e++) begin
                w_q[e] <= w_d[e];
            end
        end
    end

endmodule

// File: tb/tb_perceptron_bp_pipelined.sv
// Directed bench for perceptron_bp_pipelined: default instance plus a
// narrow-weight instance for saturation.
module tb_perceptron_bp_pipelined;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [31:0] req_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic [15:0] pred_ghr;
    logic        fb_valid;
    logic        fb_ready;
    logic [31:0] fb_pc;
    logic [15:0] fb_ghr;
    logic        fb_taken;
    logic        fb_mispredict;

    logic        s_req_valid;
    logic [31:0] s_req_pc;
    logic        s_pred_valid;
    logic        s_pred_taken;
    logic [15:0] s_pred_ghr;
    logic        s_fb_valid;
    logic        s_fb_ready;
    logic [31:0] s_fb_pc;
    logic [15:0] s_fb_ghr;
    logic        s_fb_taken;
    logic        s_fb_mispredict;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    perceptron_bp_pipelined dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_pc(req_pc),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .pred_ghr(pred_ghr),
        .fb_valid(fb_valid), .fb_ready(fb_ready),
        .fb_pc(fb_pc), .fb_ghr(fb_ghr),
        .fb_taken(fb_taken), .fb_mispredict(fb_mispredict)
    );

    perceptron_bp_pipelined #(.WEIGHT_W(4), .THETA(200)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(s_req_valid), .req_pc(s_req_pc),
        .pred_valid(s_pred_valid), .pred_taken(s_pred_taken),
        .pred_ghr(s_pred_ghr),
        .fb_valid(s_fb_valid), .fb_ready(s_fb_ready),
        .fb_pc(s_fb_pc), .fb_ghr(s_fb_ghr),
        .fb_taken(s_fb_taken), .fb_mispredict(s_fb_mispredict)
    );

    typedef struct {
        logic [31:0] pc;
        logic [15:0] ghr;
        logic        taken;
        int          exp_w;
    } fb_vec_t;

    typedef struct {
        logic valid;
        logic exp_ready;
    } rdy_vec_t;

    fb_vec_t  t3 [10];
    rdy_vec_t t6 [7];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int wa(input int r, input int k);
        wa = int'($signed(dut_a.w_q[r][k]));
    endfunction

    function automatic int wb(input int r, input int k);
        wb = int'($signed(dut_b.w_q[r][k]));
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_req(input logic [31:0] pc);
        @(negedge clk);
        req_valid = 1'b1;
        req_pc = pc;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic fb_send(input logic [31:0] pc, input logic [15:0] ghr,
                           input logic tk, input logic mp);
        int n;
        n = 0;
        @(negedge clk);
        while (!fb_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!fb_ready) begin
            total_cnt++;
            $display("FAIL fb_ready_timeout: got 0 expected 1");
        end
        fb_valid = 1'b1;
        fb_pc = pc;
        fb_ghr = ghr;
        fb_taken = tk;
        fb_mispredict = mp;
        @(negedge clk);
        fb_valid = 1'b0;
        fb_mispredict = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 10; i++) begin
            t3[i].pc = 32'h40;
            t3[i].ghr = 16'hFFFF;
            t3[i].taken = 1'b1;
            t3[i].exp_w = (i < 2) ? i + 1 : 3;
        end
        for (int i = 0; i < 7; i++) begin
            t6[i].valid = 1'b1;
            t6[i].exp_ready = (i % 3 == 0);
        end

        rst_n = 1'b0;
        req_valid = 0; req_pc = 0;
        fb_valid = 0; fb_pc = 0; fb_ghr = 0;
        fb_taken = 0; fb_mispredict = 0;
        s_req_valid = 0; s_req_pc = 0;
        s_fb_valid = 0; s_fb_pc = 0; s_fb_ghr = 0;
        s_fb_taken = 0; s_fb_mispredict = 0;

        repeat (3) @(negedge clk);
        check("rst_pred_valid", 32'(pred_valid), 0);
        check("rst_pred_taken", 32'(pred_taken), 0);
        check("rst_pred_ghr", 32'(pred_ghr), 0);
        check("rst_fb_ready", 32'(fb_ready), 1);
        rst_n = 1'b1;

        do_req(32'h100);
        check("t1_pred_valid", 32'(pred_valid), 1);
        check("t1_pred_taken", 32'(pred_taken), 1);
        check("t1_pred_ghr", 32'(pred_ghr), 0);
        @(negedge clk);
        check("t1_valid_drop", 32'(pred_valid), 0);
        check("t1_taken_hold", 32'(pred_taken), 1);

        do_reset();
        fb_send(32'h100, 16'h0000, 1'b0, 1'b0);
        check("t2_w0", 32'(wa(0, 0)), 32'hFFFF_FFFF);
        check("t2_w1", 32'(wa(0, 1)), 1);
        check("t2_w16", 32'(wa(0, 16)), 1);
        do_req(32'h100);
        check("t2_pred_taken", 32'(pred_taken), 0);
        check("t2_pred_ghr", 32'(pred_ghr), 0);

        for (int i = 0; i < 10; i++) begin
            fb_send(t3[i].pc, t3[i].ghr, t3[i].taken, 1'b0);
            check($sformatf("t3_w0_%0d", i), 32'(wa(16, 0)), 32'(t3[i].exp_w));
            check($sformatf("t3_w16_%0d", i), 32'(wa(16, 16)), 32'(t3[i].exp_w));
        end
        do_req(32'h40);
        check("t3_pred_taken", 32'(pred_taken), 0);

        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            check($sformatf("t4_ready_%0d", i), 32'(s_fb_ready), 1);
            s_fb_valid = 1'b1;
            s_fb_pc = 32'h40;
            s_fb_ghr = 16'hFFFF;
            s_fb_taken = 1'b1;
            @(negedge clk);
            s_fb_valid = 1'b0;
            @(negedge clk);
            @(negedge clk);
        end
        for (int k = 0; k <= 16; k++) begin
            check($sformatf("t4_w%0d", k), 32'(wb(16, k)), 7);
        end

        do_reset();
        do_req(32'h100);
        check("t5_ghr0", 32'(pred_ghr), 32'h0000);
        do_req(32'h100);
        check("t5_ghr1", 32'(pred_ghr), 32'h0001);
        do_req(32'h100);
        check("t5_ghr2", 32'(pred_ghr), 32'h0003);
        @(negedge clk);
        req_valid = 1'b1;
        req_pc = 32'h100;
        fb_valid = 1'b1;
        fb_pc = 32'h200;
        fb_ghr = 16'h00F0;
        fb_taken = 1'b1;
        fb_mispredict = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        fb_valid = 1'b0;
        fb_mispredict = 1'b0;
        check("t5_same_cycle_ghr", 32'(pred_ghr), 32'h0007);
        check("t5_same_cycle_taken", 32'(pred_taken), 1);
        do_req(32'h100);
        check("t5_restored_ghr", 32'(pred_ghr), 32'h01E1);
        repeat (2) @(negedge clk);

        do_reset();
        @(negedge clk);
        fb_pc = 32'h80;
        fb_ghr = 16'hFFFF;
        fb_taken = 1'b1;
        fb_mispredict = 1'b0;
        for (int i = 0; i < 7; i++) begin
            fb_valid = t6[i].valid;
            check($sformatf("t6_ready_%0d", i), 32'(fb_ready),
                  32'(t6[i].exp_ready));
            @(negedge clk);
        end
        fb_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_trainings", 32'(wa(32, 0)), 3);
        check("t6_ready_after", 32'(fb_ready), 1);

        fb_valid = 1'b1;
        fb_pc = 32'h84;
        @(negedge clk);
        fb_valid = 1'b0;
        @(negedge clk);
        check("t6_in_write_ready", 32'(fb_ready), 0);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_w_row32", 32'(wa(32, 0)), 0);
        check("t6_rst_w_row33", 32'(wa(33, 0)), 0);
        check("t6_rst_ready", 32'(fb_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_abandoned_write", 32'(wa(33, 1)), 0);
        check("t6_ready_idle", 32'(fb_ready), 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
